// File: rtl/t11_truth_table_checker.sv
// Sequencer that sweeps a 4-input element through all 16 input vectors and
// compares each response against ~((a & b) | (c ^ d)), counting mismatches.
module t11_truth_table_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       o_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       mismatch,
  output logic [4:0] err_count,
  output logic [3:0] first_err_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  function automatic logic expected_resp(input logic [3:0] idx);
    return ~((idx[3] & idx[2]) | (idx[1] ^ idx[0]));
  endfunction

  state_t     state_q, state_d;
  logic [3:0] index_q, index_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       mismatch_q, mismatch_d;
  logic [4:0] err_q, err_d;
  logic [3:0] first_q, first_d;
  logic       fail_s;

  assign fail_s = (o_in != expected_resp(index_q));

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    mismatch_d = 1'b0;
    err_d      = err_q;
    first_d    = first_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          index_d = 4'd0;
          cnt_d   = 4'd0;
          err_d   = 5'd0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q < SETTLE_L) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = 4'd0;
          if (fail_s) begin
            mismatch_d = 1'b1;
            err_d      = (err_q == 5'd16) ? err_q : err_q + 5'd1;
            first_d    = (err_q == 5'd0) ? index_q : first_q;
          end else begin
            mismatch_d = 1'b0;
          end
          // The final err_count decides pass on the same edge as done.
          if (index_q == 4'd15) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_d == 5'd0);
          end else begin
            index_d = index_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      index_q    <= 4'd0;
      cnt_q      <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= 5'd0;
      first_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      first_q    <= first_d;
    end
  end

  assign {a, b, c, d}  = index_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign mismatch      = mismatch_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_t11_truth_table_checker.sv
// Randomized self-checking bench for t11_truth_table_checker against a
// table-driven model of the element response and sweep timing.
module tb_t11_truth_table_checker;

  localparam int S = 1;
  localparam int N = 16 * (S + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       o_in;
  logic       a, b, c, d;
  logic       busy, done, pass, mismatch;
  logic [4:0] err_count;
  logic [3:0] first_err_idx;

  logic [15:0] resp_tbl;
  int n_vec = 0;
  int n_bad = 0;

  t11_truth_table_checker #(.SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .o_in(o_in),
    .a(a), .b(b), .c(c), .d(d),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  // Element under test: looks up the response for the applied vector.
  always_comb o_in = resp_tbl[{a, b, c, d}];

  // Truth of ~((i3&i2)|(i1^i0)): true only for low pairs 00/11 below index 12.
  function automatic bit truth(input int i);
    return (i < 12) && ((i % 4 == 0) || (i % 4 == 3));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_abcd"}, {28'd0, a, b, c, d}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_pass"}, {31'd0, pass}, 32'd0);
    check_eq({tag, "_mm"}, {31'd0, mismatch}, 32'd0);
    check_eq({tag, "_err"}, {27'd0, err_count}, 32'd0);
    check_eq({tag, "_first"}, {28'd0, first_err_idx}, 32'd0);
  endtask

  // mode: 0 correct, 1 tied 0, 2 tied 1, 3 inverted, 4 random
  task automatic load_table(input int mode);
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0: resp_tbl[i] = truth(i);
        1: resp_tbl[i] = 1'b0;
        2: resp_tbl[i] = 1'b1;
        3: resp_tbl[i] = !truth(i);
        default: resp_tbl[i] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic run_sweep(input bit hold, input bit rnd_start,
                           input int want_err, input int want_first);
    int tot, first, err_now, idx, i;
    bit mm_exp;
    tot = 0;
    first = -1;
    for (int j = 0; j < 16; j++) begin
      if (resp_tbl[j] != truth(j)) begin
        if (first < 0) first = j;
        tot++;
      end
    end
    if (want_err >= 0) check_eq("model_err", tot, want_err);
    if (want_first >= 0) check_eq("model_first", first, want_first);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    check_eq("k0_busy", {31'd0, busy}, 32'd1);
    check_eq("k0_abcd", {28'd0, a, b, c, d}, 32'd0);
    check_eq("k0_err", {27'd0, err_count}, 32'd0);
    check_eq("k0_pass", {31'd0, pass}, 32'd0);
    for (int k = 1; k <= N + 1; k++) begin
      @(posedge clk);
      #1;
      idx = (k / (S + 1) > 15) ? 15 : k / (S + 1);
      mm_exp = 1'b0;
      if (k % (S + 1) == 0 && k <= N) begin
        i = k / (S + 1) - 1;
        mm_exp = (resp_tbl[i] != truth(i));
      end
      err_now = 0;
      for (int j = 0; j < 16; j++)
        if ((S + 1) * (j + 1) <= k && resp_tbl[j] != truth(j)) err_now++;
      check_eq("abcd", {28'd0, a, b, c, d}, idx);
      check_eq("busy", {31'd0, busy}, (k < N) ? 32'd1 : 32'd0);
      check_eq("done", {31'd0, done}, (k == N) ? 32'd1 : 32'd0);
      check_eq("mismatch", {31'd0, mismatch}, {31'd0, mm_exp});
      check_eq("err_count", {27'd0, err_count}, err_now);
      check_eq("pass", {31'd0, pass}, (k >= N && tot == 0) ? 32'd1 : 32'd0);
      if (rnd_start && k < N - 1) start = 1'($urandom_range(0, 1));
      else if (!hold) start = 1'b0;
    end
    if (tot != 0) check_eq("first_err_idx", {28'd0, first_err_idx}, first);
  endtask

  task automatic abort_sweep();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
    end
    check_eq("abort_idx", {28'd0, a, b, c, d}, 32'd7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("abort");
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      check_eq("abort_nodone", {31'd0, done}, 32'd0);
      check_eq("abort_idle", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    resp_tbl = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    load_table(0); run_sweep(1'b0, 1'b0, 0, -1);
    // Outputs must hold after the sweep with start idle.
    repeat (3) @(posedge clk);
    #1;
    check_eq("hold_abcd", {28'd0, a, b, c, d}, 32'd15);
    check_eq("hold_pass", {31'd0, pass}, 32'd1);
    load_table(1); run_sweep(1'b0, 1'b0, 6, 0);
    load_table(2); run_sweep(1'b0, 1'b0, 10, 1);
    load_table(3); run_sweep(1'b0, 1'b1, 16, 0);
    load_table(0); run_sweep(1'b1, 1'b0, 0, -1);
    load_table(1); run_sweep(1'b1, 1'b0, 6, 0);
    start = 1'b0;
    abort_sweep();
    load_table(2); run_sweep(1'b0, 1'b0, 10, 1);
    for (int r = 0; r < 6; r++) begin
      load_table(4);
      run_sweep(1'b0, 1'b1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
